// File: rtl/somador_pkg.sv
// Shared constants for the pipelined adder/subtractor: default geometry and mode encoding.
package somador_pkg;
  localparam int   DEF_WIDTH  = 8;
  localparam int   DEF_STAGES = 2;
  localparam logic MODE_ADD   = 1'b0;
  localparam logic MODE_SUB   = 1'b1;
endpackage

// File: rtl/somador_estagio.sv
// One carry-chain segment: adds its slice of the operands, registers the running result,
// the segment carry-out and the operands for the segments still to come.
module somador_estagio #(
  parameter int WIDTH = 8,
  parameter int SEG   = 4,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             vin,
  input  logic             cin,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] ye,
  input  logic [WIDTH-1:0] r,
  output logic             vout,
  output logic             cout,
  output logic [WIDTH-1:0] xq,
  output logic [WIDTH-1:0] yeq,
  output logic [WIDTH-1:0] rq
);
  localparam int LO = IDX * SEG;

  logic [SEG:0]     seg;
  logic [WIDTH-1:0] r_nxt;

  assign seg = {1'b0, x[LO +: SEG]} + {1'b0, ye[LO +: SEG]} + {{SEG{1'b0}}, cin};

  always_comb begin
    r_nxt          = r;
    r_nxt[LO +: SEG] = seg[SEG-1:0];
  end

  // Data only loads with a real operand, so bubbles never disturb held results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vout <= 1'b0;
      cout <= 1'b0;
      xq   <= '0;
      yeq  <= '0;
      rq   <= '0;
    end else if (en) begin
      vout <= vin;
      if (vin) begin
        cout <= seg[SEG];
        xq   <= x;
        yeq  <= ye;
        rq   <= r_nxt;
      end
    end
  end
endmodule

// File: rtl/somador_pipe.sv
// Pipelined adder/subtractor with valid/ready handshake, carry chain split into STAGES segments.
// Define SOMADOR_OVF_EN to add the signed-overflow output ovf.
module somador_pipe
  import somador_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] A,
  output logic             Cout
`ifdef SOMADOR_OVF_EN
  ,output logic            ovf
`endif
);
  localparam int SEG = WIDTH / STAGES;

  logic                          adv;
  logic [STAGES:0]               vld_pipe;
  logic [STAGES:0]               c_pipe;
  logic [STAGES:0][WIDTH-1:0]    x_pipe;
  logic [STAGES:0][WIDTH-1:0]    ye_pipe;
  logic [STAGES:0][WIDTH-1:0]    r_pipe;
  logic                          unused_ops;

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe[STAGES];
  assign A         = r_pipe[STAGES];
  assign Cout      = c_pipe[STAGES];

  // Subtract is x + ~y + ~borrow, so the chain itself only ever adds.
  assign vld_pipe[0] = in_valid;
  assign c_pipe[0]   = (sub == MODE_ADD) ? Cin : ~Cin;
  assign x_pipe[0]   = x;
  assign ye_pipe[0]  = (sub == MODE_SUB) ? ~y : y;
  assign r_pipe[0]   = '0;

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_est
      somador_estagio #(.WIDTH(WIDTH), .SEG(SEG), .IDX(k)) u_est (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (adv),
        .vin  (vld_pipe[k]),
        .cin  (c_pipe[k]),
        .x    (x_pipe[k]),
        .ye   (ye_pipe[k]),
        .r    (r_pipe[k]),
        .vout (vld_pipe[k+1]),
        .cout (c_pipe[k+1]),
        .xq   (x_pipe[k+1]),
        .yeq  (ye_pipe[k+1]),
        .rq   (r_pipe[k+1])
      );
    end
  endgenerate

`ifdef SOMADOR_OVF_EN
  // Operand signs ride the pipe with the result, so ovf updates exactly when A does.
  assign ovf = (x_pipe[STAGES][WIDTH-1] == ye_pipe[STAGES][WIDTH-1]) &&
               (r_pipe[STAGES][WIDTH-1] != x_pipe[STAGES][WIDTH-1]);
  assign unused_ops = ^{x_pipe[STAGES][WIDTH-2:0], ye_pipe[STAGES][WIDTH-2:0]};
`else
  assign unused_ops = ^{x_pipe[STAGES], ye_pipe[STAGES]};
`endif
endmodule

// File: tb/tb_somador_pipe.sv
// Scoreboard bench for somador_pipe: directed vectors, throughput, backpressure, reset, random sweeps.
module tb_somador_pipe;
  typedef struct {
    logic [16:0] s;
    logic        f;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int ncmp = 0;
  int nbad = 0;

  // d0: 8/2, d1: 16/4, d2: 8/1
  logic iv0, ir0, cin0, sub0, ov0, or0, c0;
  logic [7:0] x0, y0, a0;
  logic iv1, ir1, cin1, sub1, ov1, or1, c1;
  logic [15:0] x1, y1, a1;
  logic iv2, ir2, cin2, sub2, ov2, or2, c2;
  logic [7:0] x2, y2, a2;
`ifdef SOMADOR_OVF_EN
  logic f0, f1, f2;
`endif

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  somador_pipe #(.WIDTH(8), .STAGES(2)) d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .x(x0), .y(y0), .Cin(cin0),
    .sub(sub0), .out_valid(ov0), .out_ready(or0), .A(a0), .Cout(c0)
`ifdef SOMADOR_OVF_EN
    , .ovf(f0)
`endif
  );
  somador_pipe #(.WIDTH(16), .STAGES(4)) d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .x(x1), .y(y1), .Cin(cin1),
    .sub(sub1), .out_valid(ov1), .out_ready(or1), .A(a1), .Cout(c1)
`ifdef SOMADOR_OVF_EN
    , .ovf(f1)
`endif
  );
  somador_pipe #(.WIDTH(8), .STAGES(1)) d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .x(x2), .y(y2), .Cin(cin2),
    .sub(sub2), .out_valid(ov2), .out_ready(or2), .A(a2), .Cout(c2)
`ifdef SOMADOR_OVF_EN
    , .ovf(f2)
`endif
  );

  // Reference: {Cout,A} = x + (sub ? ~y : y) + (sub ? !Cin : Cin) at w+1 bits.
  function automatic exp_t model(input int w, input logic [15:0] x, input logic [15:0] y,
                                 input logic cin, input logic sub);
    exp_t e;
    logic [16:0] m, ye, s;
    m  = 17'((32'd1 << w) - 1);
    ye = sub ? (~{1'b0, y} & m) : {1'b0, y};
    s  = {1'b0, x} + ye + {16'b0, sub ? ~cin : cin};
    s  = s & ((m << 1) | 17'd1);
    e.s = s;
    e.f = (x[w-1] == ye[w-1]) && (s[w-1] != x[w-1]);
    return e;
  endfunction

  task automatic rand_d0;
    x0 = 8'($urandom); y0 = 8'($urandom); cin0 = 1'($urandom); sub0 = 1'($urandom);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    ncmp += 4;
    if (ov0 !== 1'b0) begin nbad++; $display("FAIL reset_out_valid: got %b want 0", ov0); end
    if (a0 !== 8'h00) begin nbad++; $display("FAIL reset_A: got %h want 00", a0); end
    if (c0 !== 1'b0) begin nbad++; $display("FAIL reset_Cout: got %b want 0", c0); end
    if (ir0 !== 1'b1) begin nbad++; $display("FAIL reset_in_ready: got %b want 1", ir0); end
    rst_n = 1'b1;
    @(negedge clk); #1;
    ncmp++;
    if (ir0 !== 1'b1) begin nbad++; $display("FAIL post_reset_in_ready: got %b want 1", ir0); end
  endtask

  task automatic test_latency(input logic [7:0] x, input logic [7:0] y, input logic cin,
                              input logic sub, input logic [7:0] ea, input logic ec, input string tag);
    @(negedge clk);
    or0 = 1'b1; iv0 = 1'b1; x0 = x; y0 = y; cin0 = cin; sub0 = sub; #1;
    ncmp++;
    if (ir0 !== 1'b1) begin nbad++; $display("FAIL %s_accept: got in_ready=%b want 1", tag, ir0); end
    @(negedge clk);
    iv0 = 1'b0; rand_d0(); #1;
    ncmp++;
    if (ov0 !== 1'b0) begin nbad++; $display("FAIL %s_early: got out_valid=%b want 0", tag, ov0); end
    @(negedge clk); #1;
    ncmp += 3;
    if (ov0 !== 1'b1) begin nbad++; $display("FAIL %s_valid: got %b want 1", tag, ov0); end
    if (a0 !== ea) begin nbad++; $display("FAIL %s_A: got %h want %h", tag, a0, ea); end
    if (c0 !== ec) begin nbad++; $display("FAIL %s_Cout: got %b want %b", tag, c0, ec); end
  endtask

`ifdef SOMADOR_OVF_EN
  task automatic test_ovf(input logic [7:0] x, input logic [7:0] y, input logic sub,
                          input logic [7:0] ea, input string tag);
    @(negedge clk);
    or0 = 1'b1; iv0 = 1'b1; x0 = x; y0 = y; cin0 = 1'b0; sub0 = sub;
    @(negedge clk);
    iv0 = 1'b0;
    @(negedge clk); #1;
    ncmp += 3;
    if (ov0 !== 1'b1) begin nbad++; $display("FAIL %s_valid: got %b want 1", tag, ov0); end
    if (a0 !== ea) begin nbad++; $display("FAIL %s_A: got %h want %h", tag, a0, ea); end
    if (f0 !== 1'b1) begin nbad++; $display("FAIL %s_ovf: got %b want 1", tag, f0); end
  endtask
`endif

  task automatic test_back_to_back;
    exp_t e;
    int nacc = 0, nout = 0, cyc = 0;
    q0.delete();
    or0 = 1'b1;
    while (cyc < 30 && nout < 8) begin
      @(negedge clk);
      iv0 = (nacc < 8); rand_d0(); #1;
      if (ov0 && or0) begin
        ncmp++;
        if (q0.size() == 0) begin nbad++; $display("FAIL b2b_extra: got result %h want none", a0); end
        else begin
          e = q0.pop_front();
          if ({8'b0, c0, a0} !== e.s) begin nbad++; $display("FAIL b2b_data: got %h want %h", {c0, a0}, e.s[8:0]); end
`ifdef SOMADOR_OVF_EN
          ncmp++;
          if (f0 !== e.f) begin nbad++; $display("FAIL b2b_ovf: got %b want %b", f0, e.f); end
`endif
        end
        nout++;
      end
      if (iv0) begin
        ncmp++;
        if (ir0 !== 1'b1) begin nbad++; $display("FAIL b2b_in_ready: got %b want 1", ir0); end
        else begin q0.push_back(model(8, {8'b0, x0}, {8'b0, y0}, cin0, sub0)); nacc++; end
      end
      cyc++;
    end
    iv0 = 1'b0;
    ncmp += 2;
    if (nout != 8) begin nbad++; $display("FAIL b2b_count: got %0d want 8", nout); end
    if (cyc != 10) begin nbad++; $display("FAIL b2b_throughput: got %0d cycles want 10", cyc); end
  endtask

  task automatic test_backpressure;
    exp_t e, h;
    int nacc = 0, nout = 0, cyc = 0;
    q0.delete();
    while (cyc < 40 && nout < 4) begin
      @(negedge clk);
      or0 = (cyc >= 5); iv0 = (nacc < 4); rand_d0(); #1;
      if (cyc >= 2 && cyc <= 4) begin
        h = q0[0];
        ncmp += 3;
        if (ir0 !== 1'b0) begin nbad++; $display("FAIL bp_in_ready: got %b want 0", ir0); end
        if (ov0 !== 1'b1) begin nbad++; $display("FAIL bp_valid: got %b want 1", ov0); end
        if (a0 !== h.s[7:0]) begin nbad++; $display("FAIL bp_hold_A: got %h want %h", a0, h.s[7:0]); end
      end
      if (ov0 && or0) begin
        ncmp++;
        if (q0.size() == 0) begin nbad++; $display("FAIL bp_extra: got result %h want none", a0); end
        else begin
          e = q0.pop_front();
          if ({8'b0, c0, a0} !== e.s) begin nbad++; $display("FAIL bp_data: got %h want %h", {c0, a0}, e.s[8:0]); end
        end
        nout++;
      end
      if (iv0 && ir0) begin q0.push_back(model(8, {8'b0, x0}, {8'b0, y0}, cin0, sub0)); nacc++; end
      cyc++;
    end
    iv0 = 1'b0;
    ncmp += 2;
    if (nout != 4) begin nbad++; $display("FAIL bp_count: got %0d want 4", nout); end
    if (q0.size() != 0) begin nbad++; $display("FAIL bp_leftover: got %0d want 0", q0.size()); end
  endtask

  task automatic test_reset_mid;
    int stale = 0;
    or0 = 1'b1;
    @(negedge clk); iv0 = 1'b1; x0 = 8'h12; y0 = 8'h34; cin0 = 1'b0; sub0 = 1'b0;
    @(negedge clk); x0 = 8'hF0; y0 = 8'h0F; cin0 = 1'b1;
    @(negedge clk); iv0 = 1'b0; rst_n = 1'b0; #1;
    ncmp += 3;
    if (ov0 !== 1'b0) begin nbad++; $display("FAIL rmid_valid: got %b want 0", ov0); end
    if (a0 !== 8'h00) begin nbad++; $display("FAIL rmid_A: got %h want 00", a0); end
    if (ir0 !== 1'b1) begin nbad++; $display("FAIL rmid_in_ready: got %b want 1", ir0); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      if (ov0 !== 1'b0) stale++;
    end
    ncmp++;
    if (stale != 0) begin nbad++; $display("FAIL rmid_stale: got %0d valid cycles want 0", stale); end
    q0.delete();
  endtask

  task automatic test_random1;
    exp_t e;
    for (int i = 0; i < 420; i++) begin
      @(negedge clk);
      if (i < 400) begin
        iv1 = ($urandom_range(3) != 0); or1 = ($urandom_range(3) != 0);
      end else begin
        iv1 = 1'b0; or1 = 1'b1;
      end
      x1 = 16'($urandom); y1 = 16'($urandom); cin1 = 1'($urandom); sub1 = 1'($urandom); #1;
      if (ov1 && or1) begin
        ncmp++;
        if (q1.size() == 0) begin nbad++; $display("FAIL rnd16_extra: got %h want none", a1); end
        else begin
          e = q1.pop_front();
          if ({c1, a1} !== e.s) begin nbad++; $display("FAIL rnd16_data: got %h want %h", {c1, a1}, e.s); end
`ifdef SOMADOR_OVF_EN
          ncmp++;
          if (f1 !== e.f) begin nbad++; $display("FAIL rnd16_ovf: got %b want %b", f1, e.f); end
`endif
        end
      end
      if (iv1 && ir1) q1.push_back(model(16, x1, y1, cin1, sub1));
    end
    ncmp++;
    if (q1.size() != 0) begin nbad++; $display("FAIL rnd16_lost: got %0d pending want 0", q1.size()); end
  endtask

  task automatic test_random2;
    exp_t e;
    for (int i = 0; i < 320; i++) begin
      @(negedge clk);
      if (i < 300) begin
        iv2 = ($urandom_range(3) != 0); or2 = ($urandom_range(3) != 0);
      end else begin
        iv2 = 1'b0; or2 = 1'b1;
      end
      x2 = 8'($urandom); y2 = 8'($urandom); cin2 = 1'($urandom); sub2 = 1'($urandom); #1;
      if (ov2 && or2) begin
        ncmp++;
        if (q2.size() == 0) begin nbad++; $display("FAIL rnd8_extra: got %h want none", a2); end
        else begin
          e = q2.pop_front();
          if ({8'b0, c2, a2} !== e.s) begin nbad++; $display("FAIL rnd8_data: got %h want %h", {c2, a2}, e.s[8:0]); end
`ifdef SOMADOR_OVF_EN
          ncmp++;
          if (f2 !== e.f) begin nbad++; $display("FAIL rnd8_ovf: got %b want %b", f2, e.f); end
`endif
        end
      end
      if (iv2 && ir2) q2.push_back(model(8, {8'b0, x2}, {8'b0, y2}, cin2, sub2));
    end
    ncmp++;
    if (q2.size() != 0) begin nbad++; $display("FAIL rnd8_lost: got %0d pending want 0", q2.size()); end
  endtask

  initial begin
    iv0 = 0; or0 = 1; x0 = 0; y0 = 0; cin0 = 0; sub0 = 0;
    iv1 = 0; or1 = 1; x1 = 0; y1 = 0; cin1 = 0; sub1 = 0;
    iv2 = 0; or2 = 1; x2 = 0; y2 = 0; cin2 = 0; sub2 = 0;
    test_reset();
    test_latency(8'h55, 8'hCC, 1'b1, 1'b0, 8'h22, 1'b1, "add55cc");
    test_latency(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, "sub10_01");
    test_latency(8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, "sub00_01");
`ifdef SOMADOR_OVF_EN
    test_ovf(8'h7F, 8'h01, 1'b0, 8'h80, "ovf_add");
    test_ovf(8'h80, 8'h01, 1'b1, 8'h7F, "ovf_sub");
`endif
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_latency(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, "after_reset");
    test_random1();
    test_random2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
